// File: rtl/grid_board_render.sv
// grid_board_render: three-stage VGA overlay that draws an N x N tile grid
// with borders, a per-cell glyph read from an external font ROM and a cursor
// highlight. Every clk carries one pixel; there is no handshake and no
// backpressure, so all *_in signals reappear on *_out exactly 3 clk later.
//   S1: grid coordinates from the timing counters (registered).
//   S2: cell value select, font ROM address (combinational from S1), flags
//       registered while the synchronous ROM returns its line.
//   S3: pixel priority mux into the output registers.
module grid_board_render #(
  parameter int          MAX_N      = 16,
  parameter int          VAL_W      = 5,
  parameter int          CELL_W     = 32,
  parameter int          ORIGIN_X   = 128,
  parameter int          ORIGIN_Y   = 64,
  parameter logic [11:0] LINE_RGB   = 12'hFFF,
  parameter logic [11:0] TILE_RGB   = 12'h248,
  parameter logic [11:0] EMPTY_RGB  = 12'h000,
  parameter logic [11:0] CURSOR_RGB = 12'h4A4,
  parameter logic [11:0] TEXT_RGB   = 12'hFF0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [$clog2(MAX_N+1)-1:0]     board_size,
  input  logic [$clog2(MAX_N)-1:0]       cursor_row,
  input  logic [$clog2(MAX_N)-1:0]       cursor_col,
  input  logic [MAX_N*MAX_N*VAL_W-1:0]   board_flat,
  input  logic [10:0]                    vcount_in,
  input  logic [10:0]                    hcount_in,
  input  logic                           vsync_in,
  input  logic                           hsync_in,
  input  logic                           vblnk_in,
  input  logic                           hblnk_in,
  input  logic [11:0]                    rgb_in,
  output logic [10:0]                    rom_addr,
  input  logic [15:0]                    rom_data,
  output logic [10:0]                    vcount_out,
  output logic [10:0]                    hcount_out,
  output logic                           vsync_out,
  output logic                           hsync_out,
  output logic                           vblnk_out,
  output logic                           hblnk_out,
  output logic [11:0]                    rgb_out
);

  localparam int SZ_W  = $clog2(MAX_N+1);
  localparam int IDX_W = $clog2(MAX_N);
  localparam int SH    = $clog2(CELL_W);
  localparam int G     = (CELL_W - 16) / 2;
  localparam int IDXB  = $clog2(MAX_N*MAX_N*VAL_W);
  localparam logic [SZ_W-1:0] MAX_SZ = SZ_W'(MAX_N);

  // frame latch state
  logic             vsync_d;
  logic [SZ_W-1:0]  size_lat;
  logic [IDX_W-1:0] cur_row_lat, cur_col_lat;
  logic             vsync_rise;

  assign vsync_rise = vsync_in & ~vsync_d;

  // Latch size (clamped) and cursor only on the vsync_in rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d     <= 1'b0;
      size_lat    <= '0;
      cur_row_lat <= '0;
      cur_col_lat <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (vsync_rise) begin
        size_lat    <= (board_size > MAX_SZ) ? MAX_SZ : board_size;
        cur_row_lat <= cursor_row;
        cur_col_lat <= cursor_col;
      end
    end
  end

  // S1 combinational geometry; size 0 gives a zero extent, so nothing is in grid
  logic [10:0] dx, dy;
  logic [31:0] extent;
  logic        in_grid_c;
  assign dx        = hcount_in - 11'(ORIGIN_X);
  assign dy        = vcount_in - 11'(ORIGIN_Y);
  assign extent    = 32'(size_lat) << SH;
  assign in_grid_c = (hcount_in >= 11'(ORIGIN_X)) && (vcount_in >= 11'(ORIGIN_Y)) &&
                     (32'(dx) < extent) && (32'(dy) < extent);

  logic [10:0]      s1_vc, s1_hc;
  logic             s1_vs, s1_hs, s1_vb, s1_hb;
  logic [11:0]      s1_rgb;
  logic             s1_act, s1_edge, s1_cur;
  logic [IDX_W-1:0] s1_row, s1_col;
  logic [SH-1:0]    s1_xo, s1_yo;

  // S1 registers: delayed timing plus cell coordinates and in-cell offsets
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vc <= '0; s1_hc <= '0;
      s1_vs <= 1'b0; s1_hs <= 1'b0; s1_vb <= 1'b0; s1_hb <= 1'b0;
      s1_rgb <= '0;
      s1_act <= 1'b0; s1_edge <= 1'b0; s1_cur <= 1'b0;
      s1_row <= '0; s1_col <= '0; s1_xo <= '0; s1_yo <= '0;
    end else begin
      s1_vc  <= vcount_in; s1_hc <= hcount_in;
      s1_vs  <= vsync_in;  s1_hs <= hsync_in;
      s1_vb  <= vblnk_in;  s1_hb <= hblnk_in;
      s1_rgb <= rgb_in;
      s1_act <= enable && in_grid_c;
      // right/bottom outer border lines
      s1_edge <= (32'(dx) == extent - 32'd1) || (32'(dy) == extent - 32'd1);
      s1_row  <= dy[SH +: IDX_W];
      s1_col  <= dx[SH +: IDX_W];
      s1_xo   <= dx[SH-1:0];
      s1_yo   <= dy[SH-1:0];
      // a cursor outside the latched size never matches an in-grid cell
      s1_cur  <= (dy[SH +: IDX_W] == cur_row_lat) && (dx[SH +: IDX_W] == cur_col_lat);
    end
  end

  // S2 combinational: live cell value and glyph window
  logic [IDXB-1:0]  cell_base;
  logic [VAL_W-1:0] cell_v;
  logic             glyph_c, border_c;
  logic [3:0]       xg, yg;
  assign cell_base = IDXB'((int'(s1_row) * MAX_N + int'(s1_col)) * VAL_W);
  assign cell_v    = board_flat[cell_base +: VAL_W];
  assign glyph_c   = s1_act &&
                     (int'(s1_xo) >= G) && (int'(s1_xo) <= G + 15) &&
                     (int'(s1_yo) >= G) && (int'(s1_yo) <= G + 15);
  assign xg        = s1_xo[3:0] - 4'(G);
  assign yg        = s1_yo[3:0] - 4'(G);
  assign border_c  = (s1_xo == '0) || (s1_yo == '0) || s1_edge;
  assign rom_addr  = glyph_c ? {7'(cell_v), yg} : 11'd0;

  logic [10:0] s2_vc, s2_hc;
  logic        s2_vs, s2_hs, s2_vb, s2_hb;
  logic [11:0] s2_rgb;
  logic        s2_act, s2_border, s2_glyph, s2_cur, s2_vzero;
  logic [3:0]  s2_xg;

  // S2 registers: hold pixel flags while the ROM line is fetched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vc <= '0; s2_hc <= '0;
      s2_vs <= 1'b0; s2_hs <= 1'b0; s2_vb <= 1'b0; s2_hb <= 1'b0;
      s2_rgb <= '0;
      s2_act <= 1'b0; s2_border <= 1'b0; s2_glyph <= 1'b0;
      s2_cur <= 1'b0; s2_vzero <= 1'b0; s2_xg <= '0;
    end else begin
      s2_vc  <= s1_vc;  s2_hc <= s1_hc;
      s2_vs  <= s1_vs;  s2_hs <= s1_hs;
      s2_vb  <= s1_vb;  s2_hb <= s1_hb;
      s2_rgb <= s1_rgb;
      s2_act    <= s1_act;
      s2_border <= border_c;
      s2_glyph  <= glyph_c && (cell_v != '0);
      s2_cur    <= s1_cur;
      s2_vzero  <= (cell_v == '0);
      s2_xg     <= xg;
    end
  end

  // S3: pixel priority mux into the output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcount_out <= '0; hcount_out <= '0;
      vsync_out <= 1'b0; hsync_out <= 1'b0; vblnk_out <= 1'b0; hblnk_out <= 1'b0;
      rgb_out <= '0;
    end else begin
      vcount_out <= s2_vc; hcount_out <= s2_hc;
      vsync_out  <= s2_vs; hsync_out  <= s2_hs;
      vblnk_out  <= s2_vb; hblnk_out  <= s2_hb;
      if (s2_vb || s2_hb)                           rgb_out <= 12'h000;
      else if (!s2_act)                             rgb_out <= s2_rgb;
      else if (s2_border)                           rgb_out <= LINE_RGB;
      else if (s2_glyph && rom_data[4'd15 - s2_xg]) rgb_out <= TEXT_RGB;
      else if (s2_cur)                              rgb_out <= CURSOR_RGB;
      else if (s2_vzero)                            rgb_out <= EMPTY_RGB;
      else                                          rgb_out <= TILE_RGB;
    end
  end

endmodule

// File: tb/tb_grid_board_render.sv
// Bench for grid_board_render: directed and random pixels, a font ROM model,
// and a reference model of the grid drawing rules feeding an expected queue.
module tb_grid_board_render;

  localparam int MAX_N    = 16;
  localparam int VAL_W    = 5;
  localparam int CELL_W   = 32;
  localparam int ORIGIN_X = 128;
  localparam int ORIGIN_Y = 64;
  localparam int G        = (CELL_W - 16) / 2;
  localparam logic [11:0] LINE_C   = 12'hFFF;
  localparam logic [11:0] TILE_C   = 12'h248;
  localparam logic [11:0] EMPTY_C  = 12'h000;
  localparam logic [11:0] CURSOR_C = 12'h4A4;
  localparam logic [11:0] TEXT_C   = 12'hFF0;

  // clock / reset / DUT signals
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [4:0] board_size = '0;
  logic [3:0] cursor_row = '0, cursor_col = '0;
  logic [MAX_N*MAX_N*VAL_W-1:0] board_flat = '0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [10:0] vcount_out, hcount_out;
  logic vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  grid_board_render dut (
    .clk(clk), .rst(rst), .enable(enable), .board_size(board_size),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .board_flat(board_flat),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_data(rom_data),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out),
    .vblnk_out(vblnk_out), .hblnk_out(hblnk_out), .rgb_out(rgb_out)
  );

  // synchronous font ROM
  logic [15:0] rom_mem [2048];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // reference model state
  typedef struct {
    int h, v;
    bit vs, hs, vb, hb, en;
    logic [11:0] rgb;
    int n, cr, cc;
  } pix_t;

  int   cells [MAX_N][MAX_N];
  int   m_size = 0, m_cr = 0, m_cc = 0;
  bit   m_prev_vs = 1'b0;
  pix_t prev;
  bit   have_prev = 1'b0;

  // scoreboard
  logic [37:0] exp_q[$];
  logic [10:0] rom_q[$];
  int n_checks = 0, n_fail = 0;
  bit mon_on = 1'b0;
  int mon_cyc = 0;

  task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [37:0] out_bundle();
    return {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out};
  endfunction

  // Expected pixel and ROM address; cells hold the board as seen in S2
  function automatic void push_expect(input pix_t p);
    int dx, dy, ext, row, col, xo, yo, val, ra;
    bit in_grid, glyph;
    logic [11:0] pix;
    logic [15:0] line;
    ext = p.n * CELL_W;
    dx  = p.h - ORIGIN_X;
    dy  = p.v - ORIGIN_Y;
    in_grid = p.en && p.h >= ORIGIN_X && p.v >= ORIGIN_Y && dx < ext && dy < ext;
    row = 0; col = 0; xo = 0; yo = 0; val = 0; ra = 0; glyph = 1'b0;
    if (in_grid) begin
      row = dy / CELL_W;  col = dx / CELL_W;
      xo  = dx % CELL_W;  yo  = dy % CELL_W;
      val = cells[row][col];
      glyph = xo >= G && xo < G + 16 && yo >= G && yo < G + 16;
      if (glyph) ra = val * 16 + (yo - G);
    end
    line = rom_mem[ra];
    if (p.vb || p.hb) pix = 12'h000;
    else if (!in_grid) pix = p.rgb;
    else if (xo == 0 || yo == 0 || dx == ext - 1 || dy == ext - 1) pix = LINE_C;
    else if (glyph && val != 0 && line[15 - (xo - G)]) pix = TEXT_C;
    else if (row == p.cr && col == p.cc) pix = CURSOR_C;
    else if (val == 0) pix = EMPTY_C;
    else pix = TILE_C;
    exp_q.push_back({11'(p.v), 11'(p.h), p.vs, p.hs, p.vb, p.hb, pix});
    rom_q.push_back(11'(ra));
  endfunction

  // driver: one pixel per clk, inputs change 1 time unit after negedge
  task automatic drive(input int h, input int v, input bit vs, input bit hs,
                       input bit vb, input bit hb, input logic [11:0] rgb, input bit en);
    pix_t p;
    @(negedge clk); #1;
    rst = 1'b1;
    hcount_in = 11'(h); vcount_in = 11'(v);
    vsync_in = vs; hsync_in = hs; vblnk_in = vb; hblnk_in = hb;
    rgb_in = rgb; enable = en;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        board_flat[(r*MAX_N+c)*VAL_W +: VAL_W] = VAL_W'(cells[r][c]);
    if (have_prev) push_expect(prev);
    p.h = h; p.v = v; p.vs = vs; p.hs = hs; p.vb = vb; p.hb = hb;
    p.rgb = rgb; p.en = en; p.n = m_size; p.cr = m_cr; p.cc = m_cc;
    if (vs && !m_prev_vs) begin
      m_size = (int'(board_size) > MAX_N) ? MAX_N : int'(board_size);
      m_cr = int'(cursor_row);
      m_cc = int'(cursor_col);
    end
    m_prev_vs = vs;
    prev = p;
    have_prev = 1'b1;
  endtask

  task automatic px(input int h, input int v);
    drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom), 1'b1);
  endtask

  task automatic frame_latch(input int size, input int cr, input int cc);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom), 1'b1);
    board_size = 5'(size); cursor_row = 4'(cr); cursor_col = 4'(cc);
    drive(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'($urandom), 1'b1);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom), 1'b1);
  endtask

  // reset with live inputs; outputs and rom_addr must clear immediately
  task automatic do_reset();
    @(negedge clk); #1;
    mon_on = 1'b0;
    rst = 1'b0;
    hcount_in = 11'd200; vcount_in = 11'd100; rgb_in = 12'hABC;
    vsync_in = 1'b0; hsync_in = 1'b1; vblnk_in = 1'b0; hblnk_in = 1'b0; enable = 1'b1;
    exp_q.delete(); rom_q.delete();
    have_prev = 1'b0; m_size = 0; m_cr = 0; m_cc = 0; m_prev_vs = 1'b0;
    #1;
    check("reset_out_async", out_bundle(), '0);
    check("reset_rom_addr", {27'd0, rom_addr}, '0);
    @(posedge clk); @(negedge clk);
    check("reset_out_held", out_bundle(), '0);
    mon_cyc = 0;
    mon_on = 1'b1;
  endtask

  // monitor: outputs of the pixel driven 3 clk earlier; pipeline holds zeros after reset
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (mon_cyc < 3) check("pix_fill", out_bundle(), '0);
        else if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pix_underflow @%0t: got %h expected none", $time, out_bundle());
        end else check("pix", out_bundle(), exp_q.pop_front());
        mon_cyc++;
      end
    end
  end

  // ROM address monitor: S1 pixel together with the live board
  initial begin
    forever begin
      @(negedge clk); #2;
      if (mon_on && rom_q.size() > 0)
        check("rom_addr", {27'd0, rom_addr}, {27'd0, rom_q.pop_front()});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
    rom_mem[83] = 16'h8000;
    rom_mem[84] = 16'h0000;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++) cells[r][c] = $urandom_range(0, 31);
    cells[0][0] = 3; cells[1][2] = 5; cells[3][3] = 7;

    // reset, then first pixel must appear 3 clk after release
    do_reset();
    drive(200, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0);

    // passthrough with sync pulses and blanking
    for (int i = 0; i < 24; i++)
      drive($urandom_range(0, 799), $urandom_range(0, 524), i == 5 || i == 6, i == 10,
            i % 7 == 3, i % 9 == 4, 12'($urandom), 1'b0);

    // borders and tiles at size 4, cursor (3,3)
    frame_latch(4, 3, 3);
    px(128, 70); px(255, 70); px(256, 70); px(140, 70);
    // glyph fetch
    px(200, 107); px(200, 108);
    // size change takes effect only after vsync rise; clamp 20 -> 16
    board_size = 5'd8;
    px(300, 70);
    frame_latch(8, 3, 3);
    px(300, 70);
    frame_latch(20, 3, 3);
    px(639, 70); px(640, 70); px(620, 400);
    // cursor highlight, empty cell, out-of-range cursor
    frame_latch(4, 3, 3);
    px(225, 165);
    cells[3][3] = 0;
    frame_latch(4, 0, 0);
    px(225, 165);
    frame_latch(4, 5, 5);
    px(225, 165);
    cells[3][3] = 9;
    px(225, 165); px(160, 100);

    // randomized frames
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0)
        frame_latch($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0)
        for (int k = 0; k < 8; k++)
          cells[$urandom_range(0, 15)][$urandom_range(0, 15)] = $urandom_range(0, 31);
      drive($urandom_range(110, 680), $urandom_range(50, 620),
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            12'($urandom), $urandom_range(0, 7) != 0);
    end

    // mid-frame reset: grid stays off until the next vsync rise
    do_reset();
    px(200, 107); px(140, 70); px(225, 165);
    frame_latch(6, 1, 2);
    px(200, 107); px(140, 70); px(300, 200);

    // flush the pipeline
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_board_render.md
Name: grid_board_render

Overview:
- Parametrised successor of the fixed 16x16 board and board-number draw stages.
- Single pipelined VGA overlay stage. It draws an N x N tile grid with borders, a per-cell numeric glyph fetched from an external font ROM, and a cursor highlight.
- Sits between draw_bg output and final VGA output. It replaces the chained board and number draw stages and their second ROM port.

Parameters:
- MAX_N, 16: maximum cells per side.
- VAL_W, 5: bits per cell value, 1..7.
- CELL_W, 32: cell pitch in pixels; power of 2, at least 32.
- ORIGIN_X, 128: grid left edge, hcount.
- ORIGIN_Y, 64: grid top edge, vcount.
- LINE_RGB, 12'hFFF: border colour.
- TILE_RGB, 12'h248: non-empty cell fill.
- EMPTY_RGB, 12'h000: value-0 cell fill.
- CURSOR_RGB, 12'h4A4: cursor cell fill.
- TEXT_RGB, 12'hFF0: glyph colour.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  game active; 0 = passthrough
- board_size  in  $clog2(MAX_N+1)  cells per side
- cursor_row  in  $clog2(MAX_N)  cursor cell row
- cursor_col  in  $clog2(MAX_N)  cursor cell column
- board_flat  in  MAX_N*MAX_N*VAL_W  row-major; cell (r,c) occupies bits [(r*MAX_N+c)*VAL_W +: VAL_W]
- vcount_in, hcount_in  in  11 each  timing counters
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  sync and blanking
- rgb_in  in  12  upstream pixel
- rom_addr  out  11  font ROM address {value, glyph_line[3:0]}
- rom_data  in  16  font ROM line; valid 1 clk after rom_addr; bit 15 = leftmost pixel
- vcount_out, hcount_out  out  11 each  delayed counters
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  delayed
- rgb_out  out  12  composed pixel

Behaviour:
- Reset (rst=0, async): all outputs and pipeline registers 0, latched size 0, latched cursor 0.
- Latency: fixed 3 clk from any *_in to the matching *_out, for all signals, in every mode, including enable=0.
- Frame latch: board_size, cursor_row and cursor_col are sampled only on the clk where vsync_in rises (registered edge detect). board_flat is not latched; it is sampled live in S2.
- Size clamp: latched size > MAX_N is clamped to MAX_N. Latched size 0 means the grid is disabled.
- S1:
  - dx = hcount_in - ORIGIN_X; dy = vcount_in - ORIGIN_Y.
  - in_grid = hcount_in >= ORIGIN_X && vcount_in >= ORIGIN_Y && dx < N*CELL_W && dy < N*CELL_W.
  - col = dx >> log2(CELL_W); row likewise. xo = dx mod CELL_W; yo likewise. No divider.
- S2:
  - Select value v from board_flat at (row,col).
  - G = (CELL_W-16)/2. in_glyph = xo, yo both in [G, G+15].
  - rom_addr = {v zero-extended to 7 bits, (yo-G)[3:0]} when in_glyph, otherwise 0.
  - border = xo==0 || yo==0 || dx==N*CELL_W-1 || dy==N*CELL_W-1.
- S3 pixel priority:
  1. hblnk or vblnk (delayed) -> 12'h000.
  2. !enable || size==0 || !in_grid -> rgb_in (delayed).
  3. border -> LINE_RGB.
  4. in_glyph && v!=0 && rom_data[15-(xo-G)] -> TEXT_RGB.
  5. (row,col)==latched cursor -> CURSOR_RGB.
  6. v==0 -> EMPTY_RGB.
  7. otherwise TILE_RGB.
- Cursor outside the latched size: no cell is highlighted.
- Edge cases:
  - enable toggling mid-line takes effect on the pixel entering S1 that clk.
  - Reset mid-frame: outputs 0 at once; after release, the grid stays disabled until the next vsync_in rise.

Test Plan:
1. Reset: rst=0 with hcount_in=200, rgb_in=12'hABC -> all outputs 0. Release rst -> rgb_out=12'hABC and hcount_out=200 exactly 3 clk after inputs.
2. Passthrough: enable=0, vsync_in/hsync_in pulse at clk k -> vsync_out/hsync_out pulse at clk k+3. rgb_out equals rgb_in delayed 3 clk. rom_addr stays 0.
3. Borders: size=4 latched, hcount_in=128/vcount_in=70 -> LINE_RGB. hcount_in=255 -> LINE_RGB. hcount_in=256 -> rgb_in passthrough. hcount_in=140/vcount_in=70 with cell (0,0) value 3 -> TILE_RGB.
4. Glyph fetch: cell (1,2)=5, hcount_in=200, vcount_in=107 -> rom_addr=83 one clk after S1. ROM returns 16'h8000 -> rgb_out=TEXT_RGB. ROM returns 16'h0000 -> TILE_RGB.
5. Frame latch: board_size 4->8 mid-frame -> pixel at hcount_in=300 still passthrough. After next vsync_in rise -> border/tile at hcount_in=300. board_size=20 -> clamped to 16.
6. Cursor: cursor (3,3), size 4 -> pixel hcount_in=225/vcount_in=165 gives CURSOR_RGB. Cell value 0 gives EMPTY_RGB when cursor moved elsewhere. Cursor (5,5) with size 4 -> no highlight.
